pcm_rec_buff: RTL and testbench

Audio capture ring buffer: the reverse path of the PCM playback buffer. At every DAC sample strobe it captures one stereo 16-bit sample pair into an 8 KB byte ring. The MCU drains the ring byte-by-byte over the PI bus. It sits in the mapper next to the DAC controllers, taking the same DacBus and the same PI address window, and uses the existing `ram_dp8` as storage.

---
 rtl/pcm_rec_buff_pkg.sv | 28 ++
 rtl/ram_dp8.sv | 22 ++
 rtl/pcm_rec_buff.sv | 147 ++++++++++++++
 tb/tb_pcm_rec_buff.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_rec_buff_pkg.sv
// Shared PCM buffer constants and the capture FSM state type.
// The playback buffer uses the same constants.
package pcm_rec_buff_pkg;

    localparam int PCM_BUF_AW      = 13;
    localparam int PCM_FRAME_BYTES = 2352;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR0  = 3'd1,
        WR1  = 3'd2,
        WR2  = 3'd3,
        WR3  = 3'd4
    } pcm_wr_st_t;

    // Byte lane of the held sample written in each WRx state: L lo, L hi, R lo, R hi.
    function automatic logic [1:0] wr_lane(input pcm_wr_st_t st);
        logic [1:0] lane;
        case (st)
            WR1:     lane = 2'd1;
            WR2:     lane = 2'd2;
            WR3:     lane = 2'd3;
            default: lane = 2'd0;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/ram_dp8.sv
// Simple dual-port byte RAM: port A writes, port B gives a registered read.
module ram_dp8 #(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [7:0]    din_a,
    input  logic [AW-1:0] addr_b,
    output logic [7:0]    dout_b
);

    logic [7:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
        dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/pcm_rec_buff.sv
// Audio capture ring buffer: stereo 16-bit samples in, bytes out to the PI bus.
// A sample is written as four bytes and committed atomically by one pointer bump.
module pcm_rec_buff
    import pcm_rec_buff_pkg::*;
#(
    parameter int BUF_AW    = PCM_BUF_AW,
    parameter int RD_THRESH = PCM_FRAME_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dac_clk,
    input  logic              dac_next_sample,
    input  logic              rec,
    input  logic [15:0]       snd_l,
    input  logic [15:0]       snd_r,
    input  logic              rd_req,
    input  logic              addr_rst,
    output logic [7:0]        dato,
    output logic              can_rd,
    output logic              empty,
    output logic              overrun,
    output logic [BUF_AW-1:0] level
);

    // A new sample only fits while at least 4 bytes remain below the 2^AW-4 ceiling.
    localparam logic [BUF_AW-1:0] ROOM_MAX = {BUF_AW{1'b1}} - BUF_AW'(7);
    localparam logic [BUF_AW-1:0] THRESH   = BUF_AW'(RD_THRESH);

    pcm_wr_st_t        st_q, st_d;
    logic [31:0]       hold_q, hold_d;
    logic [BUF_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [BUF_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [BUF_AW-1:0] level_q, level_d;
    logic              overrun_q, overrun_d;
    logic              empty_q, empty_d;
    logic              can_rd_q, can_rd_d;
    logic [7:0]        dato_q, dato_d;

    logic              sample_ev;
    logic [BUF_AW-1:0] lvl_now;
    logic              ram_we;
    logic [BUF_AW-1:0] ram_waddr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_q;

    assign sample_ev = dac_clk & dac_next_sample & rec;
    assign lvl_now   = wr_ptr_q - rd_ptr_q;

    assign ram_we    = (st_q != IDLE);
    assign ram_waddr = wr_ptr_q + BUF_AW'(wr_lane(st_q));
    assign ram_wdata = hold_q[{wr_lane(st_q), 3'b000} +: 8];

    ram_dp8 #(
        .AW(BUF_AW)
    ) u_ram (
        .clk    (clk),
        .we_a   (ram_we),
        .addr_a (ram_waddr),
        .din_a  (ram_wdata),
        .addr_b (rd_ptr_q),
        .dout_b (ram_q)
    );

    always_comb begin
        st_d      = st_q;
        hold_d    = hold_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;

        if (addr_rst) begin
            st_d      = IDLE;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            overrun_d = 1'b0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (sample_ev) begin
                        if (lvl_now <= ROOM_MAX) begin
                            hold_d = {snd_r, snd_l};
                            st_d   = WR0;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                WR0: st_d = WR1;
                WR1: st_d = WR2;
                WR2: st_d = WR3;
                WR3: begin
                    st_d     = IDLE;
                    wr_ptr_d = wr_ptr_q + BUF_AW'(4);
                end
                default: st_d = IDLE;
            endcase

            // An event arriving mid-sequence cannot be held anywhere.
            if (sample_ev && st_q != IDLE) begin
                overrun_d = 1'b1;
            end

            if (rd_req && lvl_now != '0) begin
                rd_ptr_d = rd_ptr_q + BUF_AW'(1);
            end
        end

        level_d  = lvl_now;
        empty_d  = (lvl_now == '0);
        can_rd_d = (lvl_now >= THRESH);
        dato_d   = ram_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            empty_q   <= 1'b1;
            can_rd_q  <= 1'b0;
            dato_q    <= '0;
        end else begin
            st_q      <= st_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
            empty_q   <= empty_d;
            can_rd_q  <= can_rd_d;
            dato_q    <= dato_d;
        end
    end

    // Sample hold is pure data; it is only consumed after being loaded.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign dato    = dato_q;
    assign can_rd  = can_rd_q;
    assign empty   = empty_q;
    assign overrun = overrun_q;
    assign level   = level_q;

endmodule

// File: tb/tb_pcm_rec_buff.sv
// Scoreboard bench for pcm_rec_buff: expected bytes are queued when a sample is
// issued and popped by a monitor on every checked read strobe.
module tb_pcm_rec_buff;

    logic        clk = 1'b0;
    logic        rst;
    logic        dac_clk, dac_next_sample, rec;
    logic [15:0] snd_l, snd_r;
    logic        rd_req, addr_rst;
    logic [7:0]  dato;
    logic        can_rd, empty, overrun;
    logic [12:0] level;
    logic        chk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    pcm_rec_buff #(
        .BUF_AW   (13),
        .RD_THRESH(2352)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dac_clk        (dac_clk),
        .dac_next_sample(dac_next_sample),
        .rec            (rec),
        .snd_l          (snd_l),
        .snd_r          (snd_r),
        .rd_req         (rd_req),
        .addr_rst       (addr_rst),
        .dato           (dato),
        .can_rd         (can_rd),
        .empty          (empty),
        .overrun        (overrun),
        .level          (level)
    );

    // Monitor: the byte presented on dato when a checked read is issued.
    always @(negedge clk) begin
        if (chk && rd_req) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_data: actual %02h, no byte expected", dato);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (dato !== e) begin
                    n_err++;
                    $display("FAIL rd_data: actual %02h required %02h", dato, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick(input logic ev, input logic rd, input logic fl, input logic ck,
                        input logic [15:0] l, input logic [15:0] r);
        dac_clk = ev; dac_next_sample = ev; rec = ev;
        snd_l = l; snd_r = r;
        rd_req = rd; addr_rst = fl; chk = ck;
        @(posedge clk); #1;
        dac_clk = 1'b0; dac_next_sample = 1'b0; rec = 1'b0;
        rd_req = 1'b0; addr_rst = 1'b0; chk = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push_sample(input logic [15:0] l, input logic [15:0] r);
        exp_q.push_back(l[7:0]);
        exp_q.push_back(l[15:8]);
        exp_q.push_back(r[7:0]);
        exp_q.push_back(r[15:8]);
    endtask

    task automatic sample(input logic [15:0] l, input logic [15:0] r, input logic acc);
        if (acc) push_sample(l, r);
        tick(1'b1, 1'b0, 1'b0, 1'b0, l, r);
        idle(5);
    endtask

    task automatic rd_byte();
        tick(1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0);
        idle(3);
    endtask

    task automatic flush();
        tick(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        idle(2);
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        dac_clk = 1'b0; dac_next_sample = 1'b0; rec = 1'b0;
        snd_l = '0; snd_r = '0; rd_req = 1'b0; addr_rst = 1'b0; chk = 1'b0;
        #12;
        check("rst_dato", dato, 0);
        check("rst_can_rd", can_rd, 0);
        check("rst_empty", empty, 1);
        check("rst_overrun", overrun, 0);
        check("rst_level", level, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Strobe with rec low must not capture.
        dac_clk = 1'b1; dac_next_sample = 1'b1; rec = 1'b0;
        @(posedge clk); #1;
        dac_clk = 1'b0; dac_next_sample = 1'b0;
        idle(5);
        check("rec_low_level", level, 0);

        // Single sample
        sample(16'h1234, 16'hABCD, 1'b1);
        check("single_level4", level, 4);
        check("single_empty0", empty, 0);
        rd_byte(); rd_byte();
        check("single_level2", level, 2);
        rd_byte(); rd_byte();
        check("single_level0", level, 0);
        check("single_empty1", empty, 1);

        // Threshold
        flush();
        for (int i = 0; i < 587; i++) sample(16'(i * 3 + 1), 16'(16'hA000 ^ i), 1'b1);
        check("thr_level_2348", level, 2348);
        check("thr_can_rd_below", can_rd, 0);
        sample(16'(587 * 3 + 1), 16'(16'hA000 ^ 587), 1'b1);
        check("thr_level_2352", level, 2352);
        check("thr_can_rd_at", can_rd, 1);
        rd_byte();
        check("thr_level_2351", level, 2351);
        check("thr_can_rd_after", can_rd, 0);
        flush();
        exp_q.delete();
        check("flush_level", level, 0);

        // Overrun: 2047 samples fill the ring to 8188, the next one is dropped.
        for (int i = 0; i < 2047; i++) sample(16'(i * 7 + 3), 16'(~i), 1'b1);
        check("ovr_level_full", level, 8188);
        check("ovr_not_yet", overrun, 0);
        check("ovr_can_rd", can_rd, 1);
        sample(16'(2047 * 7 + 3), 16'(~2047), 1'b0);
        check("ovr_level_hold", level, 8188);
        check("ovr_set", overrun, 1);
        for (int i = 0; i < 8188; i++) rd_byte();
        check("ovr_drain_level", level, 0);
        check("ovr_drain_empty", empty, 1);
        check("ovr_queue_used", exp_q.size(), 0);

        // Wrap: pointers start at 8188 and cross 8191->0 while streaming.
        for (int i = 0; i < 25; i++) sample(16'(16'h0100 + i), 16'(16'h8000 + i), 1'b1);
        check("wrap_prefill", level, 100);
        for (int i = 25; i < 225; i++) begin
            push_sample(16'(16'h0100 + i), 16'(16'h8000 + i));
            tick(1'b1, 1'b1, 1'b0, 1'b1, 16'(16'h0100 + i), 16'(16'h8000 + i));
            idle(3);
            for (int k = 0; k < 3; k++) rd_byte();
        end
        idle(2);
        check("wrap_level_steady", level, 100);
        for (int i = 0; i < 100; i++) rd_byte();
        check("wrap_drain_level", level, 0);
        check("wrap_overrun_sticky", overrun, 1);

        // Flush collision with the FSM in WR2.
        flush();
        check("fl_overrun_clear", overrun, 0);
        sample(16'h1111, 16'h2222, 1'b0);
        check("fl_pre_level", level, 4);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h5566, 16'h7788);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 16'hEEEE, 16'hEEEE);
        check("fl_busy_drop", overrun, 1);
        idle(1);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
        idle(5);
        check("fl_level", level, 0);
        check("fl_empty", empty, 1);
        check("fl_overrun", overrun, 0);
        sample(16'h9ABC, 16'hDEF0, 1'b1);
        for (int i = 0; i < 4; i++) rd_byte();
        check("fl_after_empty", empty, 1);
        // rd_ptr=4 holds the WR0 byte of the discarded sample.
        check("empty_dato_before", dato, 8'h66);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(4);
        check("empty_dato_hold", dato, 8'h66);
        check("empty_level", level, 0);
        sample(16'h0F1E, 16'h2D3C, 1'b1);
        for (int i = 0; i < 4; i++) rd_byte();
        check("empty_rdptr_level", level, 0);

        // Async reset during WR1.
        sample(16'h4444, 16'h5555, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h6666, 16'h7777);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 16'h8888, 16'h9999);
        check("ar_pre_overrun", overrun, 1);
        check("ar_pre_level", level, 4);
        #2 rst = 1'b1;
        #1;
        check("ar_dato", dato, 0);
        check("ar_can_rd", can_rd, 0);
        check("ar_empty", empty, 1);
        check("ar_overrun", overrun, 0);
        check("ar_level", level, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(6);
        check("ar_no_commit", level, 0);
        check("ar_empty_after", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
